// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, bus widths and command record for the
// SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int SDRAM_AW = 21;
    localparam int SDRAM_DW = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;

    typedef struct packed {
        logic                  we;
        logic [SDRAM_AW-1:0]   addr;
        logic [SDRAM_DW-1:0]   wdata;
        logic [SDRAM_DW/8-1:0] be;
    } cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational winner selection between loader (0) and CPU (1).
// SDRAM_ARB_RR_EN selects round-robin; otherwise fixed priority with a burst limit.
module sdram_arb_pick #(
    parameter int MAX_BURST = 8,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          req0,
    input  logic          req1,
    input  logic          init_done,
`ifdef SDRAM_ARB_RR_EN
    input  logic          rr_ptr,
`else
    input  logic          last_owner,
    input  logic [CW-1:0] burst_cnt,
`endif
    output logic          valid,
    output logic          sel
);

    logic e1;

    always_comb begin
        e1    = req1 & init_done;
        valid = req0 | e1;
`ifdef SDRAM_ARB_RR_EN
        sel   = (req0 & e1) ? rr_ptr : e1;
`else
        // port 0 only yields to a waiting port 1 after a full burst of its own
        sel   = (req0 & e1) ? (!last_owner && burst_cnt >= CW'(MAX_BURST)) : e1;
`endif
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises loader and CPU word accesses onto the single
// SDRAM controller port, one outstanding access. Macro SDRAM_ARB_RR_EN = round-robin.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW        = SDRAM_AW,
    parameter int DW        = SDRAM_DW,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_done,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_ack,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_ack,
    output logic [DW-1:0]   m1_rdata,
    output logic            ctl_req,
    output logic            ctl_we,
    output logic [AW-1:0]   ctl_addr,
    output logic [DW-1:0]   ctl_wdata,
    output logic [DW/8-1:0] ctl_be,
    input  logic            ctl_ack,
    input  logic            ctl_rvalid,
    input  logic [DW-1:0]   ctl_rdata,
    output logic [1:0]      grant
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          owner_q, owner_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ack_q, ack_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          pick_valid, pick_sel, start, capture;
`ifdef SDRAM_ARB_RR_EN
    logic          ptr_q, ptr_d;
`else
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    sdram_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .init_done (init_done),
`ifdef SDRAM_ARB_RR_EN
        .rr_ptr    (ptr_q),
`else
        .last_owner(owner_q),
        .burst_cnt (cnt_q),
`endif
        .valid     (pick_valid),
        .sel       (pick_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            owner_q  <= 1'b0;
            grant_q  <= '0;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef SDRAM_ARB_RR_EN
            ptr_q    <= 1'b0;
`else
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef SDRAM_ARB_RR_EN
            ptr_q    <= ptr_d;
`else
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_valid ? ISSUE : IDLE;
            ISSUE:   if (ctl_ack) state_d = (cmd_q.we || ctl_rvalid) ? DONE : WAIT_RD;
            WAIT_RD: if (ctl_rvalid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start    = state_q == IDLE && pick_valid;
        capture  = !cmd_q.we && ctl_rvalid && ((state_q == ISSUE && ctl_ack) || state_q == WAIT_RD);
        cmd_d    = !start ? cmd_q :
                   pick_sel ? cmd_t'{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be}
                            : cmd_t'{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
        owner_d  = start ? pick_sel : owner_q;
        grant_d  = start ? (pick_sel ? 2'b10 : 2'b01) : (state_q == DONE ? 2'b00 : grant_q);
        // ack is registered on entry to DONE so it is high exactly while in DONE
        ack_d    = state_d == DONE ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rdata0_d = (capture && !owner_q) ? ctl_rdata : rdata0_q;
        rdata1_d = (capture && owner_q) ? ctl_rdata : rdata1_q;
`ifdef SDRAM_ARB_RR_EN
        ptr_d    = state_q == DONE ? !owner_q : ptr_q;
`else
        cnt_d    = !start ? cnt_q :
                   (pick_sel == owner_q && cnt_q != '0) ?
                       (cnt_q == CW'(MAX_BURST) ? cnt_q : cnt_q + CW'(1)) : CW'(1);
`endif
    end

    assign ctl_req   = state_q == ISSUE;
    assign ctl_we    = cmd_q.we;
    assign ctl_addr  = cmd_q.addr;
    assign ctl_wdata = cmd_q.wdata;
    assign ctl_be    = cmd_q.be;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based arbitration history and a reference memory.
module tb_sdram_port_arbiter;

    localparam int AW = 21;
    localparam int DW = 32;
    localparam int MAX_BURST = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
    } xact_t;

    logic clk, rst, init_done;
    logic m0_req, m0_we, m1_req, m1_we, m0_ack, m1_ack;
    logic [AW-1:0] m0_addr, m1_addr, ctl_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ctl_wdata, ctl_rdata;
    logic [3:0] m0_be, m1_be, ctl_be;
    logic ctl_req, ctl_we, ctl_ack, ctl_rvalid;
    logic [1:0] grant;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int ack_lat = 0, rd_lat = 1, ack_cyc = 0, rv_cyc = 0;
    bit same_cyc = 0, rand_lat = 0;
    xact_t clog[$];
    int hist[$];
    logic [DW-1:0] ctl_mem[8];
    logic [DW-1:0] ref_mem[8];

    sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_be(ctl_be), .ctl_ack(ctl_ack), .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata),
        .grant(grant)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] w,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    // Expected winner from the arbitration rules and the history of completed grants.
    function automatic int exp_win(input bit e0, input bit e1);
        int run;
        int last;
        if (!e1) return e0 ? 0 : -1;
        if (!e0) return 1;
        if (hist.size() == 0) return 0;
        last = hist[hist.size()-1];
`ifdef SDRAM_ARB_RR_EN
        return last == 0 ? 1 : 0;
`else
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
        return (last == 0 && run >= MAX_BURST) ? 1 : 0;
`endif
    endfunction

    // Controller model: ack after a latency, read data from its own memory.
    initial begin
        xact_t x;
        int al, rl;
        bit sc;
        ctl_ack = 0; ctl_rvalid = 0; ctl_rdata = '0;
        forever begin
            @(negedge clk);
            ctl_ack = 0; ctl_rvalid = 0;
            if (ctl_req === 1'b1 && !rst) begin
                al = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
                rl = rand_lat ? int'($urandom_range(1, 3)) : rd_lat;
                sc = rand_lat ? 1'($urandom_range(0, 1)) : same_cyc;
                for (int i = 0; i < al && !rst; i++) @(negedge clk);
                if (!rst) begin
                    x = '{we: ctl_we, addr: ctl_addr, wdata: ctl_wdata, be: ctl_be};
                    clog.push_back(x);
                    ctl_ack = 1; ack_cyc = cyc;
                    if (x.we) ctl_mem[x.addr[2:0]] = merge(ctl_mem[x.addr[2:0]], x.wdata, x.be);
                    else if (sc) begin
                        ctl_rvalid = 1; ctl_rdata = ctl_mem[x.addr[2:0]]; rv_cyc = cyc;
                    end else begin
                        @(negedge clk);
                        ctl_ack = 0;
                        for (int i = 1; i < rl && !rst; i++) @(negedge clk);
                        if (!rst) begin
                            ctl_rvalid = 1; ctl_rdata = ctl_mem[x.addr[2:0]]; rv_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int p, input bit r, input xact_t x);
        if (p == 0) begin
            m0_req = r; m0_we = x.we; m0_addr = x.addr; m0_wdata = x.wdata; m0_be = x.be;
        end else begin
            m1_req = r; m1_we = x.we; m1_addr = x.addr; m1_wdata = x.wdata; m1_be = x.be;
        end
    endtask

    task automatic wait_ack(input int budget, output int port);
        port = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                port = m1_ack ? 1 : 0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; init_done = 0;
        drive(0, 0, '0); drive(1, 0, '0);
        repeat (3) @(negedge clk);
        compared++; if (ctl_req !== 1'b0) begin mismatched++; $display("FAIL reset_ctl_req: got %b want 0", ctl_req); end
        compared++; if (grant !== 2'b00) begin mismatched++; $display("FAIL reset_grant: got %b want 00", grant); end
        compared++; if ({m0_ack, m1_ack} !== 2'b00) begin mismatched++; $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack}); end
        compared++; if ({m0_rdata, m1_rdata} !== '0) begin mismatched++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata); end
        compared++; if ({ctl_we, ctl_addr, ctl_wdata, ctl_be} !== '0) begin mismatched++; $display("FAIL reset_cmd: got %h want 0", {ctl_we, ctl_addr, ctl_wdata, ctl_be}); end
        rst = 0;
        hist.delete(); clog.delete();
        @(negedge clk);
    endtask

    task automatic test_preinit();
        xact_t x;
        bit seen;
        int p;
        x = '{we: 1'b1, addr: 21'h100, wdata: 32'h12345678, be: 4'hf};
        ack_lat = 2; same_cyc = 0; rand_lat = 0;
        drive(1, 1, x);
        seen = 0;
        repeat (50) begin @(negedge clk); if (ctl_req) seen = 1; end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL preinit_blocked: got ctl_req seen=%b want 0", seen); end
        init_done = 1;
        wait_ack(50, p);
        compared++; if (p != 1) begin mismatched++; $display("FAIL preinit_port: got %0d want 1", p); end
        compared++; if (cyc != ack_cyc + 1) begin mismatched++; $display("FAIL preinit_ack_timing: got %0d want %0d", cyc, ack_cyc + 1); end
        compared++; if (clog.size() != 1 || clog[0] !== x) begin mismatched++; $display("FAIL preinit_cmd: got %0d entries want 1 x %h", clog.size(), x); end
        drive(1, 0, x);
        ref_mem[0] = merge(ref_mem[0], x.wdata, x.be);
        hist.push_back(1); clog.delete();
        @(negedge clk);
        compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("FAIL preinit_ack_pulse: got %b want 0", m1_ack); end
    endtask

    task automatic test_read();
        xact_t x;
        int p, t0;
        ctl_mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        ack_lat = 1; rd_lat = 3; same_cyc = 0;
        x = '{we: 1'b0, addr: 21'h0, wdata: 32'h0, be: 4'hf};
        drive(0, 1, x); t0 = cyc;
        @(negedge clk);
        compared++; if (ctl_req !== 1'b1 || cyc != t0 + 1) begin mismatched++; $display("FAIL read_req_latency: got ctl_req=%b at +%0d want 1 at +1", ctl_req, cyc - t0); end
        compared++; if (grant !== 2'b01) begin mismatched++; $display("FAIL read_grant: got %b want 01", grant); end
        wait_ack(50, p);
        compared++; if (p != 0) begin mismatched++; $display("FAIL read_port: got %0d want 0", p); end
        compared++; if (cyc != rv_cyc + 1) begin mismatched++; $display("FAIL read_ack_timing: got %0d want %0d", cyc, rv_cyc + 1); end
        compared++; if (m0_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL read_data: got %h want deadbeef", m0_rdata); end
        drive(0, 0, x);
        hist.push_back(0); clog.delete();
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        xact_t x;
        int p;
        ctl_mem[5] = $urandom; ref_mem[5] = ctl_mem[5];
        ack_lat = 1; same_cyc = 1;
        x = '{we: 1'b0, addr: 21'h5, wdata: 32'h0, be: 4'hf};
        drive(1, 1, x);
        wait_ack(50, p);
        compared++; if (p != 1) begin mismatched++; $display("FAIL same_port: got %0d want 1", p); end
        compared++; if (cyc != ack_cyc + 1) begin mismatched++; $display("FAIL same_timing: got %0d want %0d", cyc, ack_cyc + 1); end
        compared++; if (m1_rdata !== ref_mem[5]) begin mismatched++; $display("FAIL same_data: got %h want %h", m1_rdata, ref_mem[5]); end
        compared++; if (m0_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL same_hold_m0: got %h want deadbeef", m0_rdata); end
        drive(1, 0, x);
        hist.push_back(1); clog.delete();
        same_cyc = 0;
        @(negedge clk);
        compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("FAIL same_ack_pulse: got %b want 0", m1_ack); end
    endtask

    task automatic test_back_to_back();
        xact_t x[2];
        int p, e;
        ack_lat = 0;
        x[0] = '{we: 1'b1, addr: 21'h1, wdata: $urandom, be: 4'hf};
        x[1] = '{we: 1'b1, addr: 21'h2, wdata: $urandom, be: 4'hf};
        drive(0, 1, x[0]); drive(1, 1, x[1]);
        for (int k = 0; k < 27; k++) begin
            e = exp_win(1, 1);
            wait_ack(50, p);
            compared++; if (p != e) begin mismatched++; $display("FAIL burst_order[%0d]: got %0d want %0d", k, p, e); end
            if (p < 0) break;
            hist.push_back(p);
            ref_mem[x[p].addr[2:0]] = x[p].wdata;
        end
        drive(0, 0, x[0]); drive(1, 0, x[1]);
        clog.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midread();
        xact_t x;
        int p;
        ack_lat = 0; rd_lat = 20;
        x = '{we: 1'b0, addr: 21'h0, wdata: 32'h0, be: 4'hf};
        drive(0, 1, x);
        repeat (5) @(negedge clk);
        compared++; if (grant !== 2'b01) begin mismatched++; $display("FAIL rstmid_pre_grant: got %b want 01", grant); end
        rst = 1;
        drive(0, 0, x);
        #1;
        compared++; if (ctl_req !== 1'b0 || grant !== 2'b00) begin mismatched++; $display("FAIL rstmid_clear: got req=%b grant=%b want 0/00", ctl_req, grant); end
        @(negedge clk);
        compared++; if ({m0_ack, m1_ack} !== 2'b00 || m0_rdata !== '0) begin mismatched++; $display("FAIL rstmid_acks: got %b rdata %h want 00/0", {m0_ack, m1_ack}, m0_rdata); end
        repeat (2) @(negedge clk);
        rst = 0;
        hist.delete(); clog.delete();
        rd_lat = 1;
        @(negedge clk);
        x = '{we: 1'b1, addr: 21'h3, wdata: $urandom, be: 4'hf};
        drive(1, 1, x);
        wait_ack(50, p);
        compared++; if (p != 1) begin mismatched++; $display("FAIL rstmid_after: got %0d want 1", p); end
        drive(1, 0, x);
        if (p == 1) begin ref_mem[3] = x.wdata; hist.push_back(1); end
        clog.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        xact_t c[2];
        xact_t got;
        bit r[2];
        int p, e;
        logic [DW-1:0] rd;
        rand_lat = 1;
        clog.delete();
        for (int i = 0; i < 2; i++) begin
            c[i] = '{we: 1'($urandom), addr: AW'($urandom_range(0, 7)), wdata: $urandom, be: 4'($urandom)};
            r[i] = 1'($urandom);
        end
        if (!r[0] && !r[1]) r[0] = 1;
        drive(0, r[0], c[0]); drive(1, r[1], c[1]);
        for (int k = 0; k < 60; k++) begin
            e = exp_win(r[0], r[1] && init_done);
            wait_ack(100, p);
            compared++; if (p != e) begin mismatched++; $display("FAIL rand_winner[%0d]: got %0d want %0d", k, p, e); end
            if (p < 0) break;
            got = clog.size() > 0 ? clog.pop_front() : '0;
            compared++; if (got !== c[p]) begin mismatched++; $display("FAIL rand_cmd[%0d]: got %h want %h", k, got, c[p]); end
            if (!c[p].we) begin
                rd = p ? m1_rdata : m0_rdata;
                compared++; if (rd !== ref_mem[c[p].addr[2:0]]) begin mismatched++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, ref_mem[c[p].addr[2:0]]); end
            end else ref_mem[c[p].addr[2:0]] = merge(ref_mem[c[p].addr[2:0]], c[p].wdata, c[p].be);
            hist.push_back(p);
            r[p] = 1'($urandom);
            c[p] = '{we: 1'($urandom), addr: AW'($urandom_range(0, 7)), wdata: $urandom, be: 4'($urandom)};
            if (!r[0] && !r[1]) r[$urandom_range(0, 1)] = 1;
            drive(0, r[0], c[0]); drive(1, r[1], c[1]);
        end
        drive(0, 0, c[0]); drive(1, 0, c[1]);
        rand_lat = 0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin ctl_mem[i] = $urandom; ref_mem[i] = ctl_mem[i]; end
        test_reset();
        test_preinit();
        test_read();
        test_same_cycle();
        test_back_to_back();
        test_reset_midread();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
